// File: rtl/alu_seq.sv
// Bus-attached accumulator ALU: single-cycle logic/arith/compare ops, iterative 1-bit/cycle shifts.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier (op 11001).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [4:0]       op,
    inout  wire  [WIDTH-1:0] bus,
    output logic             busy,
    output logic             done
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [1:0] M_SLL = 2'd0;
    localparam logic [1:0] M_SRL = 2'd1;
    localparam logic [1:0] M_SRA = 2'd2;
    localparam logic [1:0] M_MUL = 2'd3;

    localparam logic [4:0] OP_ADD  = 5'b10000;
    localparam logic [4:0] OP_SUB  = 5'b11000;
    localparam logic [4:0] OP_SLT  = 5'b10010;
    localparam logic [4:0] OP_SLTU = 5'b10011;
    localparam logic [4:0] OP_XOR  = 5'b10100;
    localparam logic [4:0] OP_OR   = 5'b10110;
    localparam logic [4:0] OP_AND  = 5'b10111;
    localparam logic [4:0] OP_EQ   = 5'b01000;
    localparam logic [4:0] OP_NE   = 5'b01001;
    localparam logic [4:0] OP_LT   = 5'b01100;
    localparam logic [4:0] OP_GE   = 5'b01101;
    localparam logic [4:0] OP_LTU  = 5'b01110;
    localparam logic [4:0] OP_GEU  = 5'b01111;
    localparam logic [4:0] OP_SLL  = 5'b10001;
    localparam logic [4:0] OP_SRL  = 5'b10101;
    localparam logic [4:0] OP_SRA  = 5'b11101;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'b11001;
`endif

    logic                    state;
    logic        [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] acc_s;
    logic signed [WIDTH-1:0] bus_s;
    logic        [WIDTH-1:0] alu_res;
    logic                    is_multi;
    logic        [1:0]       mode_nxt;
    logic        [1:0]       mode;
    logic signed [WIDTH-1:0] sreg;
    logic signed [WIDTH-1:0] sreg_step;
    logic        [SHW-1:0]   cnt;
    logic        [WIDTH-1:0] fin_res;

    function automatic logic [WIDTH-1:0] flag_word(input logic f);
        return {{(WIDTH-1){1'b0}}, f};
    endfunction

    // Loopback with rd=wr=1 works because the operand is read from the resolved bus
    assign bus   = rd ? acc : {WIDTH{1'bz}};
    assign bus_s = bus;
    assign acc_s = acc;
    assign busy  = (state == ST_RUN);

    always_comb begin
        alu_res  = bus;
        is_multi = 1'b0;
        mode_nxt = M_SLL;
        case (op)
            OP_ADD:  alu_res = bus_s + acc_s;
            OP_SUB:  alu_res = bus_s - acc_s;
            OP_SLT,
            OP_LT:   alu_res = flag_word(bus_s < acc_s);
            OP_SLTU,
            OP_LTU:  alu_res = flag_word(bus < acc);
            OP_GE:   alu_res = flag_word(bus_s >= acc_s);
            OP_GEU:  alu_res = flag_word(bus >= acc);
            OP_EQ:   alu_res = flag_word(bus == acc);
            OP_NE:   alu_res = flag_word(bus != acc);
            OP_XOR:  alu_res = bus ^ acc;
            OP_OR:   alu_res = bus | acc;
            OP_AND:  alu_res = bus & acc;
            OP_SLL:  begin is_multi = 1'b1; mode_nxt = M_SLL; end
            OP_SRL:  begin is_multi = 1'b1; mode_nxt = M_SRL; end
            OP_SRA:  begin is_multi = 1'b1; mode_nxt = M_SRA; end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  begin is_multi = 1'b1; mode_nxt = M_MUL; end
`endif
            default: alu_res = bus;
        endcase
    end

    always_comb begin
        case (mode)
            M_SLL:        sreg_step = sreg << 1;
            M_SRA:        sreg_step = sreg >>> 1;
            M_SRL, M_MUL: sreg_step = sreg >> 1;
            default:      sreg_step = sreg;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] prod_add;

    assign prod_add = prod + (sreg[0] ? mcand : {WIDTH{1'b0}});
    assign fin_res  = (mode == M_MUL) ? prod_add : sreg;

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wr && is_multi) begin
            mcand <= acc;
            prod  <= '0;
        end else if (state == ST_RUN) begin
            mcand <= mcand << 1;
            prod  <= prod_add;
        end
    end
`else
    assign fin_res = sreg;
`endif

    // Iteration datapath: no reset, an abandoned op is discarded by the state reset
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wr && is_multi) begin
            sreg <= bus_s;
            mode <= mode_nxt;
            cnt  <= (mode_nxt == M_MUL) ? SHW'(WIDTH - 1) : acc[SHW-1:0];
        end else if (state == ST_RUN) begin
            sreg <= sreg_step;
            cnt  <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            acc   <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (wr) begin
                    if (is_multi)
                        state <= ST_RUN;
                    else
                        acc <= alu_res;
                end
            end else if (cnt == '0) begin
                state <= ST_IDLE;
                done  <= 1'b1;
                acc   <= fin_res;
            end
        end
    end

endmodule
